// File: rtl/march_pkg.sv
// march_pkg: shared state encoding, screen extents and widths for the invader march block.
package march_pkg;
  typedef enum logic [1:0] {IDLE, MARCH, LANDED} state_t;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COL_W = 3;
  localparam int POS_W = 10;
  localparam int EDGE_W = 11;
endpackage

// File: rtl/invader_march_if.sv
// invader_march_if: march control inputs and formation position outputs; anim_frame only with MARCH_ANIM_EN.
interface invader_march_if;
  import march_pkg::*;
  logic tick;
  logic start;
  logic empty;
  logic [COL_W-1:0] left_col;
  logic [COL_W-1:0] right_col;
  logic [POS_W-1:0] x_pos;
  logic [POS_W-1:0] y_pos;
  logic dir;
  logic step_pulse;
  logic landed;
`ifdef MARCH_ANIM_EN
  logic anim_frame;
  modport master (output tick, start, empty, left_col, right_col, input x_pos, y_pos, dir, step_pulse, landed, anim_frame);
  modport slave (input tick, start, empty, left_col, right_col, output x_pos, y_pos, dir, step_pulse, landed, anim_frame);
`else
  modport master (output tick, start, empty, left_col, right_col, input x_pos, y_pos, dir, step_pulse, landed);
  modport slave (input tick, start, empty, left_col, right_col, output x_pos, y_pos, dir, step_pulse, landed);
`endif
endinterface

// File: rtl/march_bounds.sv
// march_bounds: flags when the next horizontal step would push the live formation past the playfield edge.
module march_bounds
  import march_pkg::*;
#(
  parameter int unsigned X_MIN = 8,
  parameter int unsigned X_MAX = 631,
  parameter int unsigned STEP_X = 4,
  parameter int unsigned COL_PITCH = 16,
  parameter int unsigned INV_W = 12
) (
  input  logic [POS_W-1:0] x_pos,
  input  logic [COL_W-1:0] left_col,
  input  logic [COL_W-1:0] right_col,
  input  logic             dir,
  output logic             edge_hit
);
  logic [EDGE_W-1:0] l, r;
  assign l = EDGE_W'(x_pos) + EDGE_W'(left_col) * EDGE_W'(COL_PITCH);
  assign r = EDGE_W'(x_pos) + EDGE_W'(right_col) * EDGE_W'(COL_PITCH) + EDGE_W'(INV_W - 1);
  assign edge_hit = dir ? (r + EDGE_W'(STEP_X) > EDGE_W'(X_MAX)) : (l < EDGE_W'(X_MIN + STEP_X));
endmodule

// File: rtl/invader_march.sv
// invader_march: steps the alien formation per tick, descending and reversing at edges; MARCH_ANIM_EN adds anim_frame.
module invader_march
  import march_pkg::*;
#(
  parameter int unsigned X_START = 64,
  parameter int unsigned Y_START = 48,
  parameter int unsigned X_MIN = 8,
  parameter int unsigned X_MAX = SCREEN_W - 9,
  parameter int unsigned STEP_X = 4,
  parameter int unsigned STEP_Y = 8,
  parameter int unsigned Y_LAND = SCREEN_H - 80,
  parameter int unsigned COL_PITCH = 16,
  parameter int unsigned INV_W = 12
) (
  input logic clk,
  input logic rst,
  invader_march_if.slave bus
);
  state_t state, state_n;
  logic [POS_W-1:0] x_q, y_q, x_n, y_n;
  logic dir_q, dir_n, step_q, step_n, edge_hit;
  march_bounds #(.X_MIN(X_MIN), .X_MAX(X_MAX), .STEP_X(STEP_X), .COL_PITCH(COL_PITCH), .INV_W(INV_W)) u_bounds (
    .x_pos(x_q), .left_col(bus.left_col), .right_col(bus.right_col), .dir(dir_q), .edge_hit(edge_hit)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      x_q <= POS_W'(X_START);
      y_q <= POS_W'(Y_START);
      dir_q <= 1'b1;
      step_q <= 1'b0;
    end else begin
      state <= state_n;
      x_q <= x_n;
      y_q <= y_n;
      dir_q <= dir_n;
      step_q <= step_n;
    end
  end
  // start outranks a coincident tick, so a reload never also steps
  always_comb begin
    state_n = state;
    x_n = x_q;
    y_n = y_q;
    dir_n = dir_q;
    step_n = 1'b0;
    if (bus.start) begin
      state_n = MARCH;
      x_n = POS_W'(X_START);
      y_n = POS_W'(Y_START);
      dir_n = 1'b1;
    end else if (state == MARCH && bus.tick && !bus.empty) begin
      step_n = 1'b1;
      x_n = edge_hit ? x_q : dir_q ? x_q + POS_W'(STEP_X) : x_q - POS_W'(STEP_X);
      y_n = edge_hit ? y_q + POS_W'(STEP_Y) : y_q;
      dir_n = dir_q ^ edge_hit;
      state_n = (y_n >= POS_W'(Y_LAND)) ? LANDED : MARCH;
    end
  end
  assign bus.x_pos = x_q;
  assign bus.y_pos = y_q;
  assign bus.dir = dir_q;
  assign bus.step_pulse = step_q;
  assign bus.landed = state == LANDED;
`ifdef MARCH_ANIM_EN
  logic anim_q;
  always_ff @(posedge clk) begin
    if (!rst || bus.start) anim_q <= 1'b0;
    else if (step_n) anim_q <= ~anim_q;
  end
  assign bus.anim_frame = anim_q;
`endif
endmodule

// File: tb/tb_invader_march.sv
// tb_invader_march: directed march/descent/landing/reset checks with Y_LAND lowered to 64.
module tb_invader_march;
  import march_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  invader_march_if bus ();
  invader_march #(.Y_LAND(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic ticks(input int n);
    pulses = 0;
    repeat (n) begin
      bus.tick = 1'b1;
      @(posedge clk);
      #1;
      bus.tick = 1'b0;
      if (bus.step_pulse === 1'b1) pulses++;
    end
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask
  initial begin
    bus.tick = 1'b0;
    bus.start = 1'b0;
    bus.empty = 1'b0;
    bus.left_col = 3'd0;
    bus.right_col = 3'd7;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x", int'(bus.x_pos), 64);
    chk("rst_y", int'(bus.y_pos), 48);
    chk("rst_dir", int'(bus.dir), 1);
    chk("rst_step", int'(bus.step_pulse), 0);
    chk("rst_landed", int'(bus.landed), 0);
    chk("rst_state", int'(dut.state), int'(IDLE));
    rst = 1'b1;
    ticks(3);
    chk("idle_pulses", pulses, 0);
    chk("idle_x", int'(bus.x_pos), 64);
    pulse_start();
    chk("start_state", int'(dut.state), int'(MARCH));
    ticks(111);
    chk("right_pulses", pulses, 111);
    chk("right_x", int'(bus.x_pos), 508);
    chk("right_y", int'(bus.y_pos), 48);
    chk("right_dir", int'(bus.dir), 1);
    ticks(1);
    chk("desc1_step", int'(bus.step_pulse), 1);
    chk("desc1_x", int'(bus.x_pos), 508);
    chk("desc1_y", int'(bus.y_pos), 56);
    chk("desc1_dir", int'(bus.dir), 0);
    ticks(125);
    chk("left_pulses", pulses, 125);
    chk("left_x", int'(bus.x_pos), 8);
    chk("left_y", int'(bus.y_pos), 56);
    ticks(1);
    chk("desc2_step", int'(bus.step_pulse), 1);
    chk("desc2_y", int'(bus.y_pos), 64);
    chk("desc2_dir", int'(bus.dir), 1);
    chk("desc2_x", int'(bus.x_pos), 8);
    chk("landed", int'(bus.landed), 1);
    chk("landed_state", int'(dut.state), int'(LANDED));
    ticks(5);
    chk("landed_pulses", pulses, 0);
    chk("landed_x", int'(bus.x_pos), 8);
    chk("landed_y", int'(bus.y_pos), 64);
    chk("landed_hold", int'(bus.landed), 1);
    pulse_start();
    chk("restart_x", int'(bus.x_pos), 64);
    chk("restart_y", int'(bus.y_pos), 48);
    chk("restart_landed", int'(bus.landed), 0);
    bus.empty = 1'b1;
    ticks(10);
    bus.empty = 1'b0;
    chk("empty_pulses", pulses, 0);
    chk("empty_x", int'(bus.x_pos), 64);
    ticks(2);
    chk("resume_x", int'(bus.x_pos), 72);
    bus.tick = 1'b1;
    pulse_start();
    bus.tick = 1'b0;
    chk("st_tick_x", int'(bus.x_pos), 64);
    chk("st_tick_y", int'(bus.y_pos), 48);
    chk("st_tick_step", int'(bus.step_pulse), 0);
    ticks(34);
    chk("mid_x", int'(bus.x_pos), 200);
    rst = 1'b0;
    bus.tick = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.tick = 1'b0;
    chk("midrst_x", int'(bus.x_pos), 64);
    chk("midrst_y", int'(bus.y_pos), 48);
    chk("midrst_dir", int'(bus.dir), 1);
    chk("midrst_step", int'(bus.step_pulse), 0);
    chk("midrst_state", int'(dut.state), int'(IDLE));
    ticks(3);
    chk("midrst_pulses", pulses, 0);
    chk("midrst_hold_x", int'(bus.x_pos), 64);
    pulse_start();
    ticks(1);
    chk("after_x", int'(bus.x_pos), 68);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
